// File: rtl/scan_pkg.sv
// Shared types and sizes for the 4-channel analog mux scan controller.
package scan_pkg;

  localparam int unsigned NUM_CH  = 4;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned DWELL_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    HOLD   = 2'd3
  } scan_state_e;

endpackage

// File: rtl/scan_dwell_cnt.sv
// Per-channel settle counter: load, decrement toward zero, registered zero flag.
module scan_dwell_cnt
  import scan_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic [DWELL_W-1:0] load_val_i,
  input  logic               dec_en_i,
  output logic               zero_o
);

  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               zero_q;

  // Load wins over decrement; the count saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - DWELL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      zero_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      zero_q <= (cnt_d == '0);
    end
  end

  assign zero_o = zero_q;

endmodule

// File: rtl/chan_scan_ctrl.sv
// Scans 4 mux channels (settle DWELL cycles, then sample) and hands the frame off.
// Optional even-parity output is built only when CHAN_SCAN_PARITY_EN is defined.
module chan_scan_ctrl
  import scan_pkg::*;
#(
  parameter int unsigned DWELL = 4,
  parameter int unsigned CONT  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              sel_a,
  output logic              sel_b,
  output logic              mux_en,
  input  logic              mux_y,
  output logic [NUM_CH-1:0] frame,
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic              frame_par,
  output logic              busy
);

  localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL - 1);
  localparam logic [SEL_W-1:0]   LAST_CH    = SEL_W'(NUM_CH - 1);

  scan_state_e       state_q, state_d;
  logic [SEL_W-1:0]  ch_q, ch_d;
  logic [NUM_CH-1:0] frame_q, frame_d;
  logic              mux_en_q, mux_en_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic              cnt_load, cnt_dec, cnt_zero;

  scan_dwell_cnt u_dwell (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load),
    .load_val_i (DWELL_LOAD),
    .dec_en_i   (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ch_q     <= '0;
      frame_q  <= '0;
      mux_en_q <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      frame_q  <= frame_d;
      mux_en_q <= mux_en_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
    end
  end

  // Next state, channel and sample capture.
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    frame_d  = frame_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SETTLE;
          ch_d     = '0;
          cnt_load = 1'b1;
        end
      end
      SETTLE: begin
        if (cnt_zero) state_d = SAMPLE;
        else          cnt_dec = 1'b1;
      end
      SAMPLE: begin
        frame_d[ch_q] = mux_y;
        if (ch_q == LAST_CH) begin
          state_d = HOLD;
        end else begin
          state_d  = SETTLE;
          ch_d     = ch_q + SEL_W'(1);
          cnt_load = 1'b1;
        end
      end
      HOLD: begin
        if (frame_ready) begin
          if ((CONT != 0) || start) begin
            state_d  = SETTLE;
            ch_d     = '0;
            cnt_load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    mux_en_d = (state_d == SETTLE) || (state_d == SAMPLE);
    busy_d   = (state_d != IDLE);
    valid_d  = (state_d == HOLD);
  end

`ifdef CHAN_SCAN_PARITY_EN
  logic par_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_q <= 1'b0;
    else        par_q <= ^frame_d;
  end

  assign frame_par = par_q;
`else
  assign frame_par = 1'b0;
`endif

  assign sel_a       = ch_q[1];
  assign sel_b       = ch_q[0];
  assign mux_en      = mux_en_q;
  assign busy        = busy_q;
  assign frame_valid = valid_q;
  assign frame       = frame_q;

endmodule

// File: tb/tb_chan_scan_ctrl.sv
// Scoreboard bench: instance 0 (DWELL=4, CONT=0) and instance 1 (DWELL=1, CONT=1).
module tb_chan_scan_ctrl;

  localparam int DW0 = 4;
  localparam int DW1 = 1;

  typedef struct {
    logic [3:0] f;
    int         due;
  } exp_t;

  logic       clk, rst_n, noise;
  logic [1:0] start, frame_ready, mux_y;
  logic [1:0] sel_a, sel_b, mux_en, frame_valid, frame_par, busy;
  logic [3:0] frame0, frame1;

  // Reference model state: phase 0 idle, 1 scanning, 2 holding.
  int         cyc;
  int         ph[2];
  int         lc[2];
  logic [3:0] dd[2];
  logic [3:0] hf[2];
  logic [3:0] rnd[2];
  bit         used[2];
  logic [1:0] prev_fv;
  exp_t       sb0[$];
  exp_t       sb1[$];

  int checks = 0;
  int errors = 0;

  chan_scan_ctrl #(.DWELL(DW0), .CONT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]),
    .sel_a(sel_a[0]), .sel_b(sel_b[0]), .mux_en(mux_en[0]), .mux_y(mux_y[0]),
    .frame(frame0), .frame_valid(frame_valid[0]), .frame_ready(frame_ready[0]),
    .frame_par(frame_par[0]), .busy(busy[0])
  );

  chan_scan_ctrl #(.DWELL(DW1), .CONT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]),
    .sel_a(sel_a[1]), .sel_b(sel_b[1]), .mux_en(mux_en[1]), .mux_y(mux_y[1]),
    .frame(frame1), .frame_valid(frame_valid[1]), .frame_ready(frame_ready[1]),
    .frame_par(frame_par[1]), .busy(busy[1])
  );

  always #5 clk = ~clk;

  // Model mux: channel data while enabled, noise otherwise.
  logic [3:0] d0_v, d1_v;
  assign d0_v = dd[0];
  assign d1_v = dd[1];
  assign mux_y[0] = mux_en[0] ? d0_v[{sel_a[0], sel_b[0]}] : noise;
  assign mux_y[1] = mux_en[1] ? d1_v[{sel_a[1], sel_b[1]}] : noise;

  function automatic int dw(int k);
    return (k == 0) ? DW0 : DW1;
  endfunction

  function automatic int scan_len(int k);
    return 4 * (dw(k) + 1);
  endfunction

  function automatic logic epar(logic [3:0] f);
`ifdef CHAN_SCAN_PARITY_EN
    return ^f;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit launches(int k);
    if (ph[k] == 0) return start[k];
    if (ph[k] == 2) return frame_ready[k] && ((k == 1) || start[k]);
    return 1'b0;
  endfunction

  // First frame of each instance uses d0..d3 = 1,0,1,1.
  function automatic logic [3:0] new_data(int k);
    return used[k] ? rnd[k] : 4'b1101;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(int k, logic [3:0] f, int due);
    exp_t e;
    e.f = f;
    e.due = due;
    if (k == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endtask

  // High-level model: a scan launched at edge L ends in HOLD at edge L + 4*(DWELL+1).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc <= 0;
      for (int k = 0; k < 2; k++) begin
        ph[k] <= 0;
        lc[k] <= 0;
      end
      sb0.delete();
      sb1.delete();
    end else begin
      cyc <= cyc + 1;
      for (int k = 0; k < 2; k++) begin
        if (launches(k)) begin
          ph[k]   <= 1;
          lc[k]   <= cyc + 1;
          dd[k]   <= new_data(k);
          used[k] <= 1'b1;
          push_exp(k, new_data(k), cyc + 1 + scan_len(k));
        end else if (ph[k] == 1 && (cyc + 1 - lc[k]) == scan_len(k)) begin
          ph[k] <= 2;
          hf[k] <= dd[k];
        end else if (ph[k] == 2 && frame_ready[k]) begin
          ph[k] <= 0;
        end
      end
    end
  end

  task automatic check_inst(int k);
    int t;
    logic [3:0] fr;
    exp_t e;
    t  = cyc - lc[k];
    fr = (k == 0) ? frame0 : frame1;
    case (ph[k])
      0: begin
        chk($sformatf("u%0d_idle_busy", k), busy[k], 0);
        chk($sformatf("u%0d_idle_mux_en", k), mux_en[k], 0);
        chk($sformatf("u%0d_idle_valid", k), frame_valid[k], 0);
      end
      1: begin
        chk($sformatf("u%0d_scan_busy", k), busy[k], 1);
        chk($sformatf("u%0d_scan_mux_en", k), mux_en[k], 1);
        chk($sformatf("u%0d_scan_valid", k), frame_valid[k], 0);
        chk($sformatf("u%0d_scan_sel", k), {sel_a[k], sel_b[k]}, t / (dw(k) + 1));
      end
      default: begin
        chk($sformatf("u%0d_hold_busy", k), busy[k], 1);
        chk($sformatf("u%0d_hold_mux_en", k), mux_en[k], 0);
        chk($sformatf("u%0d_hold_valid", k), frame_valid[k], 1);
        chk($sformatf("u%0d_hold_frame", k), fr, hf[k]);
        chk($sformatf("u%0d_hold_par", k), frame_par[k], epar(hf[k]));
      end
    endcase
    if (frame_valid[k] && !prev_fv[k]) begin
      if ((k == 0 && sb0.size() == 0) || (k == 1 && sb1.size() == 0)) begin
        chk($sformatf("u%0d_sb_unexpected_frame", k), 1, 0);
      end else begin
        e = (k == 0) ? sb0.pop_front() : sb1.pop_front();
        chk($sformatf("u%0d_sb_frame", k), fr, e.f);
        chk($sformatf("u%0d_sb_par", k), frame_par[k], epar(e.f));
        chk($sformatf("u%0d_sb_latency", k), cyc, e.due);
      end
    end
  endtask

  // Monitor: compares DUT outputs against the model away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check_inst(0);
      check_inst(1);
      prev_fv <= frame_valid;
    end else begin
      prev_fv <= 2'b00;
    end
  end

  task automatic reset_check();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("u%0d_rst_sel_a", k), sel_a[k], 0);
      chk($sformatf("u%0d_rst_sel_b", k), sel_b[k], 0);
      chk($sformatf("u%0d_rst_mux_en", k), mux_en[k], 0);
      chk($sformatf("u%0d_rst_valid", k), frame_valid[k], 0);
      chk($sformatf("u%0d_rst_par", k), frame_par[k], 0);
      chk($sformatf("u%0d_rst_busy", k), busy[k], 0);
    end
    chk("u0_rst_frame", frame0, 0);
    chk("u1_rst_frame", frame1, 0);
  endtask

  task automatic random_phase(int n);
    repeat (n) begin
      @(negedge clk);
      start       = {1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0)};
      frame_ready = 2'($urandom);
      noise       = 1'($urandom);
      rnd[0]      = 4'($urandom);
      rnd[1]      = 4'($urandom);
    end
  endtask

  initial begin
    bit found;
    clk = 1'b0;
    rst_n = 1'b1;
    start = 2'b00;
    frame_ready = 2'b00;
    noise = 1'b0;
    used[0] = 1'b0;
    used[1] = 1'b0;
    rnd[0] = 4'h0;
    rnd[1] = 4'h0;
    prev_fv = 2'b00;
    #3 rst_n = 1'b0;
    #1 reset_check();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed scan with d = 1101, then backpressure in HOLD.
    @(negedge clk);
    start = 2'b11;
    @(negedge clk);
    start = 2'b00;
    repeat (30) @(negedge clk);
    frame_ready = 2'b11;
    @(negedge clk);
    frame_ready = 2'b00;
    repeat (5) @(negedge clk);
    frame_ready = 2'b10;
    repeat (40) @(negedge clk);

    random_phase(3000);

    // Drive a scan on instance 0 and reset it asynchronously during channel 2.
    start = 2'b00;
    frame_ready = 2'b11;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (ph[0] == 1 && (cyc - lc[0]) / (DW0 + 1) == 2) found = 1'b1;
      else start[0] = (ph[0] != 1);
    end
    chk("wait_channel2_timeout", found, 1);
    start = 2'b00;
    frame_ready = 2'b00;
    #2 rst_n = 1'b0;
    #1 reset_check();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("u0_no_valid_after_reset", frame_valid[0], 0);
    chk("u1_no_valid_after_reset", frame_valid[1], 0);

    random_phase(500);

    // Drain: everything already launched must come out.
    start = 2'b00;
    frame_ready = 2'b11;
    repeat (60) @(negedge clk);
    chk("u0_sb_drained", sb0.size(), 0);
    chk("u1_sb_at_most_one", int'(sb1.size() <= 1), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/chan_scan_ctrl.md
CHAN_SCAN_CTRL -- requirements
Module: chan_scan_ctrl

Interface
REQ-001 The block SHALL have parameter DWELL, default 4, meaning settle cycles per channel before sampling (legal range 1..255).
REQ-002 The block SHALL have parameter CONT, default 0, meaning 1 restarts scanning automatically after each frame handshake.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port start  input  1  request one scan of 4 channels; sampled only in IDLE.
REQ-006 The block SHALL have port sel_a  output  1  mux select MSB.
REQ-007 The block SHALL have port sel_b  output  1  mux select LSB.
REQ-008 The block SHALL have port mux_en  output  1  mux enable.
REQ-009 The block SHALL have port mux_y  input  1  selected mux data.
REQ-010 The block SHALL have port frame  output  4  captured samples; bit n holds channel n (n = {sel_a,sel_b}).
REQ-011 The block SHALL have port frame_valid  output  1  frame is complete and stable.
REQ-012 The block SHALL have port frame_ready  input  1  consumer accepts frame.
REQ-013 The block SHALL have port frame_par  output  1  even parity of frame (see Configuration).
REQ-014 The block SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, SETTLE, SAMPLE and HOLD.
REQ-016 In IDLE, start=1 SHALL set channel=0, load the dwell counter with DWELL-1 and go to SETTLE.
REQ-017 In SETTLE the dwell counter SHALL decrement each cycle, with transition to SAMPLE when it reads 0, so SETTLE lasts exactly DWELL cycles.
REQ-018 In SAMPLE, mux_y SHALL be registered into frame[channel] at the cycle's closing edge.
REQ-019 From SAMPLE, channel<3 SHALL increment channel, reload the counter and return to SETTLE; channel=3 SHALL go to HOLD.
REQ-020 Each channel SHALL take DWELL+1 cycles, and frame_valid SHALL rise 4*(DWELL+1) cycles after the edge that accepted start (20 cycles at DWELL=4).
REQ-021 {sel_a,sel_b} SHALL equal channel throughout SETTLE and SAMPLE, and mux_en SHALL be 1 only in SETTLE and SAMPLE.
REQ-022 In HOLD, frame_valid SHALL be 1 and frame/frame_par SHALL be held stable until frame_valid and frame_ready are both high at an edge.
REQ-023 On that handshake edge, CONT=1 or start=1 SHALL restart at channel 0 in SETTLE (back-to-back frames, no IDLE cycle); otherwise the FSM SHALL go to IDLE.
REQ-024 start SHALL be ignored in SETTLE and SAMPLE, and frame_ready SHALL be ignored outside HOLD.
REQ-025 frame bits not yet sampled in a new scan SHALL retain their previous values; only complete frames are ever marked valid.
REQ-026 The channel counter SHALL be 2 bits and SHALL never wrap inside a scan; the dwell counter width SHALL be 8 bits.

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE, channel 0, dwell counter 0, frame 0, frame_par 0, frame_valid 0, busy 0, sel_a 0, sel_b 0 and mux_en 0.
REQ-028 Reset asserted mid-scan or in HOLD SHALL discard the partial or pending frame, and no frame_valid SHALL follow reset release without a new start (or CONT after a new start).

Configuration
REQ-029 With macro CHAN_SCAN_PARITY_EN defined, frame_par SHALL equal the XOR of the 4 frame bits, registered with frame, and valid whenever frame_valid=1.
REQ-030 Without CHAN_SCAN_PARITY_EN, frame_par SHALL be tied to 0, no parity logic SHALL be built, and the port list SHALL be unchanged.

Structure
REQ-031 Package scan_pkg SHALL hold the state enum type, NUM_CH=4, SEL_W=2 and DWELL_W=8.
REQ-032 The dwell counter SHALL be a sub-module scan_dwell_cnt with inputs load, load value and decrement enable and output zero flag; all other logic SHALL reside in chan_scan_ctrl.

Verification
REQ-033 Single scan, DWELL=4, CONT=0, mux_y driven from a model mux with d0..d3=1,0,1,1: pulse start -> sel sequence 00,01,10,11 for 5 cycles each, frame_valid at cycle 20, frame=4'b1101, frame_par=1 (macro on) or 0 (macro off).
REQ-034 Backpressure: frame_ready low for 10 cycles in HOLD -> frame_valid, frame and mux_en=0 stable throughout; accepted on first ready edge, then IDLE with busy=0.
REQ-035 CONT=1 with frame_ready held at 1 -> frames back-to-back every 21 cycles (20 scan cycles + 1 HOLD cycle), and sel returns to 00 on the cycle after the handshake.
REQ-036 start pulses during SETTLE and SAMPLE -> no restart and no change in channel sequence or latency.
REQ-037 rst_n driven low asynchronously mid-channel 2 -> all outputs 0 without waiting for a clock edge; after release with no start, frame_valid stays 0 for 50 cycles.
REQ-038 DWELL=1 -> 2 cycles per channel, frame_valid at cycle 8, and sampled values match d0..d3.
